axi_burst_bridge: RTL and testbench
===================================

Name: axi_burst_bridge

Overview:
- Parametrised cache-to-AXI bridge: next generation of the single-ID cache AXI interface.
- Independent read and write engines with valid/ready request handshakes on the cache side.
- Full burst handling: beat counting, self-generated wlast, B-channel completion, error reporting.
- Flush drains in-flight AXI bursts and never abandons them. Sits between the I/D cache controllers and the SoC AXI crossbar.

Parameters:
DATA_W, 32, AXI/cache data width (32 or 64)
ADDR_W, 32, address width
ID_W, 4, AXI ID width
RD_ID, 0, constant arid value
WR_ID, 0, constant awid/wid value
MAX_LEN, 16, maximum beats per burst (power of 2, at most 256)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; discard pending results (see Behaviour)
rd_req_valid/rd_req_ready  in/out  1/1  read request handshake
rd_req_addr/rd_req_len/rd_req_size/rd_req_burst  in  ADDR_W/8/3/2  read request: len = beats-1
rd_data/rd_data_valid/rd_data_last/rd_err  out  DATA_W/1/1/1  returned beats; rd_err = rresp[1] of that beat
wr_req_valid/wr_req_ready  in/out  1/1  write request handshake
wr_req_addr/wr_req_len/wr_req_size/wr_req_burst  in  ADDR_W/8/3/2  write request
wr_data/wr_strb/wr_data_valid/wr_data_ready  in/in/in/out  DATA_W/DATA_W/8/1/1  write beats
wr_done/wr_err  out  1/1  one-cycle pulse on B accept; wr_err = bresp[1]
busy  out  1  either engine not idle
ar*/r*/aw*/w*/b*  AXI3 master ports, standard widths; lock = 0, prot = 0, cache = 4'b0000, bready held 1

Behaviour:
- Reset (async, resetn low) puts both FSMs in IDLE. All valid/ready outputs 0 except bready = 1. Address/len registers 0; rd_err/wr_err/wr_done 0.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: rd_req_ready = 1. On rd_req_valid, latch the request and go to R_ADDR with arvalid = 1 in the next cycle.
  - R_ADDR: arvalid held with stable payload until arready; go to R_DATA with rready = 1.
  - R_DATA: each rvalid & rready is one beat. rd_data/rd_data_valid are registered, 1-cycle latency. A beat counter checks rlast against len.
  - On the beat where rlast = 1: return to R_IDLE; rd_data_last pulses with the final beat.
  - Back-to-back request accepted in R_IDLE in the cycle after the last beat (no dead cycle beyond that).
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: wr_req_ready = 1; accept and go to W_ADDR.
  - W_ADDR: awvalid until awready; go to W_DATA.
  - W_DATA: wvalid = wr_data_valid, wr_data_ready = wready. Bridge counts beats and drives wlast = 1 when count == len; the cache supplies no last.
  - W_DATA exit: after the last beat handshake go to W_RESP.
  - W_RESP: on bvalid pulse wr_done (and wr_err if bresp[1]); go to W_IDLE.
- Simultaneous arready and rvalid are not possible for the same burst. The read FSM ignores rvalid outside R_DATA.
- Mismatch: rlast early or late versus counter sets rd_err on the last returned beat. The FSM still follows rlast.
- Flush:
  - In IDLE: no effect.
  - In R_ADDR/R_DATA: complete the AXI burst, but suppress rd_data_valid/rd_data_last for the rest of the transaction.
  - During writes: ignored (writes are architecturally committed); wr_done is still pulsed.
- Request acceptance is blocked while flush = 1.
- len > MAX_LEN-1 is clamped to MAX_LEN-1. Counter width is clog2(MAX_LEN).

Optional Feature:
- Macro: AXI_BRIDGE_WBUF_EN.
- With it: write beats go through a MAX_LEN-deep FIFO.
  - wr_data_ready = !fifo_full, independent of wready, so the cache may push beats during W_ADDR.
  - The W channel is fed from the FIFO head. W_RESP is entered only when the FIFO is empty after the last beat.
- Without it: wr_data_ready = wready during W_DATA only, 0 otherwise; zero buffering.

Decomposition:
- Package axi_bridge_pkg: AXBURST/AXSIZE/AXRESP encodings, read and write state typedefs, lock/prot/cache constants.
- One natural sub-module: axi_wdata_fifo (synchronous FIFO, DATA_W + DATA_W/8 wide, depth MAX_LEN), instantiated only under AXI_BRIDGE_WBUF_EN.

Test Plan:
- Read INCR len=3 at 0x1000, slave returns D0..D3 with 2-cycle arready delay → 4 rd_data_valid pulses, data in order, rd_data_last on D3, busy drops the next cycle.
- Write INCR len=7, cache stalls wr_data_valid on beat 4 → wlast asserted only on beat 8; wr_done pulses once after bvalid; wr_err = 0.
- bresp = SLVERR on single write → wr_done and wr_err both high for exactly 1 cycle.
- flush asserted at beat 2 of a len=3 read → arready/rready protocol completes (rready stays 1 through rlast), no rd_data_valid after the flush, next read accepted.
- resetn asserted low mid W_DATA → all outputs reach reset values without a clock edge; bready = 1.
- Concurrent read len=15 and write len=15 → both complete independently; rd_req_ready and wr_req_ready return to 1.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared AXI encodings, bridge FSM state types and the burst-length clamp helper
// used by the cache-to-AXI burst bridge.
package axi_bridge_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B = 3'b000;
  localparam logic [2:0] SIZE_2B = 3'b001;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [2:0] SIZE_8B = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] AX_LOCK  = 2'b00;
  localparam logic [2:0] AX_PROT  = 3'b000;
  localparam logic [3:0] AX_CACHE = 4'b0000;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rdState_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wrState_t;

  // Requests longer than the bridge can count are cut down to the longest legal burst.
  function automatic logic [7:0] clampLen(input logic [7:0] len, input int maxLen);
    if (int'({24'd0, len}) > maxLen - 1) return 8'(maxLen - 1);
    return len;
  endfunction

endpackage

// File: rtl/axi_wdata_fifo.sv
// Synchronous write-beat FIFO ({strb, data} per entry) that lets the cache run
// ahead of the W channel when the bridge is built with write buffering.
module axi_wdata_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push && !o_full)  r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop  && !o_empty) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr[AW-1:0]];
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

endmodule

// File: rtl/axi_burst_bridge.sv
// Cache-to-AXI3 burst bridge with independent read and write engines.
// Define AXI_BRIDGE_WBUF_EN to buffer write beats in a MAX_LEN-deep FIFO.
module axi_burst_bridge
  import axi_bridge_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int RD_ID   = 0,
  parameter int WR_ID   = 0,
  parameter int MAX_LEN = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  input  logic [7:0]          rd_req_len,
  input  logic [2:0]          rd_req_size,
  input  logic [1:0]          rd_req_burst,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_data_valid,
  output logic                rd_data_last,
  output logic                rd_err,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [7:0]          wr_req_len,
  input  logic [2:0]          wr_req_size,
  input  logic [1:0]          wr_req_burst,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_data_valid,
  output logic                wr_data_ready,
  output logic                wr_done,
  output logic                wr_err,
  output logic                busy,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int CNT_W = $clog2(MAX_LEN);

  rdState_t          r_rdState, w_rdNext;
  wrState_t          r_wrState, w_wrNext;
  logic              r_reqEn;
  logic [CNT_W-1:0]  r_rdCnt, r_wrCnt;
  logic              r_rdLate, r_rdFlushed;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdDataValid, r_rdDataLast, r_rdErr;
  logic [ADDR_W-1:0] r_araddr, r_awaddr;
  logic [7:0]        r_arlen, r_awlen;
  logic [2:0]        r_arsize, r_awsize;
  logic [1:0]        r_arburst, r_awburst;
  logic              r_wrDone, r_wrErr;
  logic              w_rdAccept, w_rdBeat, w_rdSuppress, w_rdCntHit;
  logic              w_wrAccept, w_wrBeat, w_wrCntHit;
  logic              w_unused;

  // Request ready is held low while reset is applied and for the first cycle after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_reqEn <= 1'b0;
    else         r_reqEn <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdState <= R_IDLE;
      r_wrState <= W_IDLE;
    end else begin
      r_rdState <= w_rdNext;
      r_wrState <= w_wrNext;
    end
  end

  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      R_IDLE:  if (w_rdAccept) w_rdNext = R_ADDR;
      R_ADDR:  if (arready) w_rdNext = R_DATA;
      R_DATA:  if (rvalid && rlast) w_rdNext = R_IDLE;
      default: w_rdNext = R_IDLE;
    endcase
  end

  always_comb begin
    rd_req_ready = (r_rdState == R_IDLE) && !flush && r_reqEn;
    arvalid      = (r_rdState == R_ADDR);
    rready       = (r_rdState == R_DATA);
  end

  assign w_rdAccept   = rd_req_valid && rd_req_ready;
  assign w_rdBeat     = (r_rdState == R_DATA) && rvalid;
  assign w_rdSuppress = r_rdFlushed || flush;
  assign w_rdCntHit   = (r_rdCnt == r_arlen[CNT_W-1:0]);

  // A beat count that disagrees with rlast is reported on the rlast beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_arsize      <= '0;
      r_arburst     <= '0;
      r_rdCnt       <= '0;
      r_rdLate      <= 1'b0;
      r_rdFlushed   <= 1'b0;
      r_rdData      <= '0;
      r_rdDataValid <= 1'b0;
      r_rdDataLast  <= 1'b0;
      r_rdErr       <= 1'b0;
    end else begin
      r_rdDataValid <= 1'b0;
      r_rdDataLast  <= 1'b0;
      r_rdErr       <= 1'b0;
      if (w_rdAccept) begin
        r_araddr    <= rd_req_addr;
        r_arlen     <= clampLen(rd_req_len, MAX_LEN);
        r_arsize    <= rd_req_size;
        r_arburst   <= rd_req_burst;
        r_rdCnt     <= '0;
        r_rdLate    <= 1'b0;
        r_rdFlushed <= 1'b0;
      end
      if (flush && r_rdState != R_IDLE) r_rdFlushed <= 1'b1;
      if (w_rdBeat) begin
        r_rdCnt       <= r_rdCnt + CNT_W'(1);
        if (w_rdCntHit && !rlast) r_rdLate <= 1'b1;
        r_rdData      <= rdata;
        r_rdDataValid <= !w_rdSuppress;
        r_rdDataLast  <= rlast && !w_rdSuppress;
        r_rdErr       <= !w_rdSuppress && (rresp[1] || (rlast && (r_rdLate || !w_rdCntHit)));
      end
    end
  end

  always_comb begin
    w_wrNext = r_wrState;
    case (r_wrState)
      W_IDLE:  if (w_wrAccept) w_wrNext = W_ADDR;
      W_ADDR:  if (awready) w_wrNext = W_DATA;
      W_DATA:  if (w_wrBeat && wlast) w_wrNext = W_RESP;
      W_RESP:  if (bvalid) w_wrNext = W_IDLE;
      default: w_wrNext = W_IDLE;
    endcase
  end

  always_comb begin
    wr_req_ready = (r_wrState == W_IDLE) && !flush && r_reqEn;
    awvalid      = (r_wrState == W_ADDR);
  end

  assign w_wrAccept = wr_req_valid && wr_req_ready;
  assign w_wrBeat   = wvalid && wready;
  assign w_wrCntHit = (r_wrCnt == r_awlen[CNT_W-1:0]);
  assign wlast      = (r_wrState == W_DATA) && w_wrCntHit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wrCnt   <= '0;
      r_wrDone  <= 1'b0;
      r_wrErr   <= 1'b0;
    end else begin
      r_wrDone <= 1'b0;
      r_wrErr  <= 1'b0;
      if (w_wrAccept) begin
        r_awaddr  <= wr_req_addr;
        r_awlen   <= clampLen(wr_req_len, MAX_LEN);
        r_awsize  <= wr_req_size;
        r_awburst <= wr_req_burst;
        r_wrCnt   <= '0;
      end
      if (w_wrBeat) r_wrCnt <= r_wrCnt + CNT_W'(1);
      if (r_wrState == W_RESP && bvalid) begin
        r_wrDone <= 1'b1;
        r_wrErr  <= bresp[1];
      end
    end
  end

`ifdef AXI_BRIDGE_WBUF_EN
  logic [DATA_W+DATA_W/8-1:0] w_fifoData;
  logic                       w_fifoFull, w_fifoEmpty, w_push;
  logic [CNT_W-1:0]           r_pushCnt;
  logic                       r_pushDone;

  // Pushes stop once the burst's beats are all buffered, so the FIFO drains empty on wlast.
  assign wr_data_ready = !w_fifoFull && !r_pushDone &&
                         (r_wrState == W_ADDR || r_wrState == W_DATA);
  assign w_push        = wr_data_valid && wr_data_ready;
  assign wvalid        = (r_wrState == W_DATA) && !w_fifoEmpty;
  assign {wstrb, wdata} = w_fifoData;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pushCnt  <= '0;
      r_pushDone <= 1'b0;
    end else if (w_wrAccept) begin
      r_pushCnt  <= '0;
      r_pushDone <= 1'b0;
    end else if (w_push) begin
      r_pushCnt <= r_pushCnt + CNT_W'(1);
      if (r_pushCnt == r_awlen[CNT_W-1:0]) r_pushDone <= 1'b1;
    end
  end

  axi_wdata_fifo #(
    .WIDTH (DATA_W + DATA_W/8),
    .DEPTH (MAX_LEN)
  ) u_wdataFifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  ({wr_strb, wr_data}),
    .i_pop   (w_wrBeat),
    .o_data  (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );
`else
  assign wvalid        = (r_wrState == W_DATA) && wr_data_valid;
  assign wdata         = wr_data;
  assign wstrb         = wr_strb;
  assign wr_data_ready = (r_wrState == W_DATA) && wready;
`endif

  assign rd_data       = r_rdData;
  assign rd_data_valid = r_rdDataValid;
  assign rd_data_last  = r_rdDataLast;
  assign rd_err        = r_rdErr;
  assign wr_done       = r_wrDone;
  assign wr_err        = r_wrErr;
  assign busy          = (r_rdState != R_IDLE) || (r_wrState != W_IDLE);

  assign arid    = ID_W'(RD_ID);
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = r_arburst;
  assign arlock  = AX_LOCK;
  assign arcache = AX_CACHE;
  assign arprot  = AX_PROT;
  assign awid    = ID_W'(WR_ID);
  assign wid     = ID_W'(WR_ID);
  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awsize  = r_awsize;
  assign awburst = r_awburst;
  assign awlock  = AX_LOCK;
  assign awcache = AX_CACHE;
  assign awprot  = AX_PROT;
  assign bready  = 1'b1;

  // Single outstanding ID per direction, so returned IDs and resp[0] carry no information.
  assign w_unused = ^{rid, bid, rresp[0], bresp[0]};

endmodule

// File: tb/tb_axi_burst_bridge.sv
// Scoreboard bench for axi_burst_bridge: directed read/write bursts against a
// simple AXI slave model, with monitors checking returned beats and write completions.
module tb_axi_burst_bridge;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;

  logic              clk, resetn, flush;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [7:0]        rd_req_len;
  logic [2:0]        rd_req_size;
  logic [1:0]        rd_req_burst;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid, rd_data_last, rd_err;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [7:0]        wr_req_len;
  logic [2:0]        wr_req_size;
  logic [1:0]        wr_req_burst;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic              wr_data_valid, wr_data_ready, wr_done, wr_err, busy;
  logic [ID_W-1:0]   arid, awid, wid, rid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, arprot, awprot;
  logic [1:0]        arburst, awburst, arlock, awlock;
  logic [3:0]        arcache, awcache;
  logic              arvalid, arready, awvalid, awready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [1:0]        rresp, bresp;
  logic              rlast, rvalid, rready;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast, wvalid, wready, bvalid, bready;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } rdExp_t;

  rdExp_t rdQ[$];
  logic   wrQ[$];
  rdExp_t rdHead;
  logic   wrHead;
  int     nCompared   = 0;
  int     nMismatched = 0;

  axi_burst_bridge dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last), .rd_err(rd_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_size(wr_req_size), .wr_req_burst(wr_req_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Present a cache-side request and hold it until the bridge accepts it.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [7:0] len);
    int guard = 0;
    if (isWrite) begin
      wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_len = len;
      wr_req_size = 3'b010; wr_req_burst = 2'b01;
    end else begin
      rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len;
      rd_req_size = 3'b010; rd_req_burst = 2'b01;
    end
    while (1) begin
      @(negedge clk);
      if (isWrite ? wr_req_ready : rd_req_ready) break;
      guard++;
      if (guard > 500) begin
        failTimeout(isWrite ? "wrReqAccept" : "rdReqAccept");
        break;
      end
    end
    @(posedge clk); #1;
    if (isWrite) wr_req_valid = 1'b0;
    else         rd_req_valid = 1'b0;
  endtask

  task automatic readSlave(input logic [31:0] expAddr, input logic [7:0] expLen, input int nBeats,
                           input int arDelay, input logic [31:0] base, input int flushBeat);
    int guard = 0;
    while (1) begin
      @(negedge clk);
      if (arvalid) break;
      guard++;
      if (guard > 500) begin failTimeout("arvalid"); return; end
    end
    repeat (arDelay) @(negedge clk);
    checkOutput("araddr", araddr, expAddr);
    checkOutput("arlen", arlen, expLen);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b < nBeats; b++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rresp  = 2'b00;
      rlast  = (b == nBeats - 1);
      if (b == flushBeat) flush = 1'b1;
      @(negedge clk);
      checkOutput("rready", rready, 1);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic cacheWrite(input logic [31:0] addr, input logic [7:0] len, input int nBeats,
                            input int stallBeat, input logic [31:0] base);
    int guard;
    applyStimulus(1'b1, addr, len);
    for (int b = 0; b < nBeats; b++) begin
      if (b == stallBeat) begin
        wr_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      wr_data_valid = 1'b1;
      wr_data       = base + 32'(b);
      wr_strb       = '1;
      guard = 0;
      while (1) begin
        @(negedge clk);
        if (wr_data_ready) break;
        guard++;
        if (guard > 500) begin failTimeout("wrDataReady"); break; end
      end
      @(posedge clk); #1;
    end
    wr_data_valid = 1'b0;
  endtask

  task automatic writeSlave(input logic [31:0] expAddr, input logic [7:0] expLen, input int nBeats,
                            input int awDelay, input logic [1:0] respIn, input logic [31:0] base);
    int guard = 0;
    int beat  = 0;
    while (1) begin
      @(negedge clk);
      if (awvalid) break;
      guard++;
      if (guard > 500) begin failTimeout("awvalid"); return; end
    end
    repeat (awDelay) @(negedge clk);
    checkOutput("awaddr", awaddr, expAddr);
    checkOutput("awlen", awlen, expLen);
    checkOutput("wvalidDuringAddr", wvalid, 0);
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    wready  = 1'b1;
    guard   = 0;
    while (beat < nBeats) begin
      @(negedge clk);
      if (wvalid) begin
        checkOutput("wlast", wlast, (beat == nBeats - 1));
        checkOutput("wdata", wdata, base + 32'(beat));
        @(posedge clk); #1;
        beat++;
      end else begin
        guard++;
        if (guard > 500) begin failTimeout("wvalid"); break; end
      end
    end
    wready = 1'b0;
    bvalid = 1'b1;
    bresp  = respIn;
    @(negedge clk);
    checkOutput("bready", bready, 1);
    @(posedge clk); #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  task automatic expectRead(input logic [31:0] base, input int nBeats, input logic lastErr);
    for (int b = 0; b < nBeats; b++)
      rdQ.push_back('{data: base + 32'(b), last: (b == nBeats - 1), err: (b == nBeats - 1) && lastErr});
  endtask

  // Read-beat monitor: every presented beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (resetn && rd_data_valid) begin
      if (rdQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL rdUnexpected: got beat %0h, expected no beat (t=%0t)", rd_data, $time);
      end else begin
        rdHead = rdQ.pop_front();
        checkOutput("rdData", rd_data, rdHead.data);
        checkOutput("rdLast", rd_data_last, rdHead.last);
        checkOutput("rdErr", rd_err, rdHead.err);
      end
    end
  end

  // Write-completion monitor: one wr_done pulse per expected write, with its error flag.
  always @(negedge clk) begin
    if (resetn && wr_done) begin
      if (wrQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL wrDoneUnexpected: got wr_done=1, expected 0 (t=%0t)", $time);
      end else begin
        wrHead = wrQ.pop_front();
        checkOutput("wrErr", wr_err, wrHead);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0; rd_req_burst = '0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0; wr_req_burst = '0;
    wr_data = '0; wr_strb = '0; wr_data_valid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;

    #23;
    checkOutput("rstArvalid", arvalid, 0);
    checkOutput("rstAwvalid", awvalid, 0);
    checkOutput("rstRready", rready, 0);
    checkOutput("rstBready", bready, 1);
    checkOutput("rstRdReqReady", rd_req_ready, 0);
    checkOutput("rstRdDataValid", rd_data_valid, 0);
    checkOutput("rstWrDone", wr_done, 0);
    checkOutput("rstArlen", arlen, 0);
    checkOutput("rstAraddr", araddr, 0);
    checkOutput("rstBusy", busy, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] read INCR len=3 with arready delay");
    expectRead(32'hD000_0000, 4, 1'b0);
    fork
      applyStimulus(1'b0, 32'h0000_1000, 8'd3);
      readSlave(32'h0000_1000, 8'd3, 4, 2, 32'hD000_0000, -1);
    join
    @(negedge clk);
    checkOutput("busyAfterRead", busy, 0);
    checkOutput("rdReqReadyAfterRead", rd_req_ready, 1);
    @(posedge clk); #1;

    $display("[TB] write INCR len=7 with cache stall");
    wrQ.push_back(1'b0);
    fork
      cacheWrite(32'h0000_2000, 8'd7, 8, 4, 32'hA000_0000);
      writeSlave(32'h0000_2000, 8'd7, 8, 1, 2'b00, 32'hA000_0000);
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] single write with SLVERR");
    wrQ.push_back(1'b1);
    fork
      cacheWrite(32'h0000_3000, 8'd0, 1, -1, 32'hB000_0000);
      writeSlave(32'h0000_3000, 8'd0, 1, 0, 2'b10, 32'hB000_0000);
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] flush at beat 2 of len=3 read, then next read");
    expectRead(32'hC000_0000, 2, 1'b0);
    rdQ[1].last = 1'b0;
    fork
      applyStimulus(1'b0, 32'h0000_4000, 8'd3);
      readSlave(32'h0000_4000, 8'd3, 4, 0, 32'hC000_0000, 2);
    join
    expectRead(32'h5000_0000, 2, 1'b0);
    fork
      applyStimulus(1'b0, 32'h0000_5000, 8'd1);
      readSlave(32'h0000_5000, 8'd1, 2, 1, 32'h5000_0000, -1);
    join
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] early rlast and clamped length");
    expectRead(32'h6000_0000, 2, 1'b1);
    fork
      applyStimulus(1'b0, 32'h0000_6000, 8'd3);
      readSlave(32'h0000_6000, 8'd3, 2, 0, 32'h6000_0000, -1);
    join
    expectRead(32'h7000_0000, 16, 1'b0);
    fork
      applyStimulus(1'b0, 32'h0000_7000, 8'd40);
      readSlave(32'h0000_7000, 8'd15, 16, 0, 32'h7000_0000, -1);
    join
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] requests blocked while flush is high");
    flush = 1'b1; rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    @(negedge clk);
    checkOutput("rdReqReadyFlush", rd_req_ready, 0);
    checkOutput("wrReqReadyFlush", wr_req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busyFlushIdle", busy, 0);
    flush = 1'b0; rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] concurrent read len=15 and write len=15");
    expectRead(32'hE000_0000, 16, 1'b0);
    wrQ.push_back(1'b0);
    fork
      applyStimulus(1'b0, 32'h0000_8000, 8'd15);
      readSlave(32'h0000_8000, 8'd15, 16, 1, 32'hE000_0000, -1);
      cacheWrite(32'h0000_9000, 8'd15, 16, -1, 32'hF000_0000);
      writeSlave(32'h0000_9000, 8'd15, 16, 3, 2'b00, 32'hF000_0000);
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rdReqReadyConcurrent", rd_req_ready, 1);
    checkOutput("wrReqReadyConcurrent", wr_req_ready, 1);
    checkOutput("busyConcurrent", busy, 0);
    @(posedge clk); #1;

    $display("[TB] reset asserted during write data phase");
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_A000; wr_req_len = 8'd3;
    @(posedge clk); #1;
    wr_req_valid = 1'b0;
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; wready = 1'b1; wr_data_valid = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    checkOutput("wrDataReadyBeforeReset", wr_data_ready, 1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checkOutput("midRstWvalid", wvalid, 0);
    checkOutput("midRstWlast", wlast, 0);
    checkOutput("midRstWrDataReady", wr_data_ready, 0);
    checkOutput("midRstAwvalid", awvalid, 0);
    checkOutput("midRstWrReqReady", wr_req_ready, 0);
    checkOutput("midRstBready", bready, 1);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstAwlen", awlen, 0);
    wready = 1'b0; wr_data_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rdQueueDrained", rdQ.size(), 0);
    checkOutput("wrQueueDrained", wrQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
